// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: opcodes, error codes, FSM states.
package calc_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_OVF   = 2'b01;
  localparam logic [1:0] ERR_DIV0  = 2'b10;
  localparam logic [1:0] ERR_BADOP = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2
  } calc_state_e;

endpackage

// File: rtl/calc_settle_timer.sv
// 4-bit loadable down-counter; done is high whenever the count is zero.
module calc_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       done
);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign done = (count == 4'd0);

endmodule

// File: rtl/calc_sequencer.sv
// Command/response front-end for the combinational calculator datapath with a chaining accumulator.
// Optional CALC_SEQ_OPCHECK_EN rejects opcodes above OP_MOD at accept with ERR_BADOP.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic        cmd_chain,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic [1:0]  alu_error,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [1:0]  rsp_error,
  output logic [31:0] acc
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("calc_sequencer: SETTLE_CYCLES must be within 1..15");
  end

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  calc_state_e state;
  logic        accept;
  logic        bad_op;
  logic        timer_load;
  logic        settle_done;

`ifdef CALC_SEQ_OPCHECK_EN
  assign bad_op = (cmd_op > OP_MOD);
`else
  assign bad_op = 1'b0;
`endif

  assign cmd_ready  = (state == IDLE);
  assign rsp_valid  = (state == RESPOND);
  assign accept     = cmd_valid && cmd_ready;
  assign timer_load = accept && !bad_op;

  calc_settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (SETTLE_LOAD),
    .en       (state == ISSUE),
    .done     (settle_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      alu_a      <= 16'd0;
      alu_b      <= 16'd0;
      alu_op     <= 4'd0;
      rsp_result <= 32'd0;
      rsp_error  <= ERR_NONE;
      acc        <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (bad_op) begin
              // Rejected opcode never reaches the datapath; answer immediately.
              rsp_result <= 32'd0;
              rsp_error  <= ERR_BADOP;
              state      <= RESPOND;
            end else begin
              // Chaining reuses only the low half of the accumulator.
              alu_a  <= cmd_chain ? acc[15:0] : cmd_a;
              alu_b  <= cmd_b;
              alu_op <= cmd_op;
              state  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (settle_done) begin
            rsp_result <= alu_result;
            rsp_error  <= alu_error;
            if (alu_error == ERR_NONE) begin
              acc <= alu_result;
            end
            state <= RESPOND;
          end
        end
        RESPOND: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed table-driven bench for calc_sequencer with a behavioural datapath stand-in.
module tb_calc_sequencer;

  localparam int SETTLE = 2;
  localparam int NVEC   = 9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = 4'd0;
  logic [15:0] cmd_a = 16'd0;
  logic [15:0] cmd_b = 16'd0;
  logic        cmd_chain = 1'b0;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic [1:0]  alu_error;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_error;
  logic [31:0] acc;

  int compared = 0;
  int mismatched = 0;

  calc_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_chain  (cmd_chain),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_error  (alu_error),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_error  (rsp_error),
    .acc        (acc)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: unsigned 16-bit operands, carry/borrow flags overflow.
  always_comb begin
    alu_result = 32'd0;
    alu_error  = 2'b00;
    case (alu_op)
      4'd0: begin
        alu_result   = {16'd0, alu_a} + {16'd0, alu_b};
        alu_error[0] = (({16'd0, alu_a} + {16'd0, alu_b}) > 32'h0000FFFF);
      end
      4'd1: begin
        alu_result   = {16'd0, 16'(alu_a - alu_b)};
        alu_error[0] = (alu_a < alu_b);
      end
      4'd2: alu_result = {16'd0, alu_a} * {16'd0, alu_b};
      4'd3: if (alu_b == 16'd0) alu_error = 2'b10; else alu_result = {16'd0, 16'(alu_a / alu_b)};
      4'd4: if (alu_b == 16'd0) alu_error = 2'b10; else alu_result = {16'd0, 16'(alu_a % alu_b)};
      default: ;
    endcase
  end

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        chain;
    logic [15:0] exp_alu_a;
    logic [31:0] exp_res;
    logic [1:0]  exp_err;
    logic [31:0] exp_acc;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Offer a command at the next edge and count edges until rsp_valid.
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic chain, input int exp_lat, input string tag);
    int cycles;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_chain = chain;
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cycles = 1;
    while (!rsp_valid && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    chk({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_valid_after"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] acc_before;
    logic [3:0]  op_before;

    vecs[0] = '{4'd0, 16'd15,    16'd126, 1'b0, 16'd15,    32'd141,    2'b00, 32'd141};
    vecs[1] = '{4'd2, 16'd999,   16'd2,   1'b1, 16'd141,   32'd282,    2'b00, 32'd282};
    vecs[2] = '{4'd3, 16'd100,   16'd0,   1'b0, 16'd100,   32'd0,      2'b10, 32'd282};
    vecs[3] = '{4'd1, 16'd0,     16'd82,  1'b1, 16'd282,   32'd200,    2'b00, 32'd200};
    vecs[4] = '{4'd0, 16'hFFFF,  16'd1,   1'b0, 16'hFFFF,  32'h10000,  2'b01, 32'd200};
    vecs[5] = '{4'd4, 16'd100,   16'd7,   1'b0, 16'd100,   32'd2,      2'b00, 32'd2};
    vecs[6] = '{4'd3, 16'd1000,  16'd7,   1'b0, 16'd1000,  32'd142,    2'b00, 32'd142};
    vecs[7] = '{4'd2, 16'd300,   16'd300, 1'b0, 16'd300,   32'd90000,  2'b00, 32'd90000};
    vecs[8] = '{4'd0, 16'd5,     16'd0,   1'b1, 16'd24464, 32'd24464,  2'b00, 32'd24464};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready",  32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid",  32'(rsp_valid), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_error",  32'(rsp_error), 32'd0);
    chk("rst_acc",        acc, 32'd0);
    chk("rst_alu_a",      32'(alu_a), 32'd0);
    chk("rst_alu_b",      32'(alu_b), 32'd0);
    chk("rst_alu_op",     32'(alu_op), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].chain, SETTLE + 1, tag);
      chk({tag, "_alu_a"},  32'(alu_a), 32'(vecs[i].exp_alu_a));
      chk({tag, "_alu_b"},  32'(alu_b), 32'(vecs[i].b));
      chk({tag, "_alu_op"}, 32'(alu_op), 32'(vecs[i].op));
      chk({tag, "_result"}, rsp_result, vecs[i].exp_res);
      chk({tag, "_error"},  32'(rsp_error), 32'(vecs[i].exp_err));
      chk({tag, "_acc"},    acc, vecs[i].exp_acc);
      consume(tag);
    end

    // Backpressure: response held for 5 cycles, a stray command is ignored.
    issue(4'd0, 16'd1, 16'd2, 1'b0, SETTLE + 1, "bp");
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 4'd2;
        cmd_a     = 16'd9;
        cmd_b     = 16'd9;
        cmd_chain = 1'b0;
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      chk($sformatf("bp_hold%0d_valid", c),  32'(rsp_valid), 32'd1);
      chk($sformatf("bp_hold%0d_result", c), rsp_result, 32'd3);
      chk($sformatf("bp_hold%0d_ready", c),  32'(cmd_ready), 32'd0);
    end
    consume("bp");
    repeat (4) @(posedge clk);
    #1;
    chk("bp_no_extra_valid", 32'(rsp_valid), 32'd0);
    chk("bp_alu_a_kept",     32'(alu_a), 32'd1);
    chk("bp_acc",            acc, 32'd3);

    // Bad opcode handling.
    acc_before = acc;
    op_before  = alu_op;
`ifdef CALC_SEQ_OPCHECK_EN
    issue(4'd7, 16'd5, 16'd6, 1'b0, 1, "bad");
    chk("bad_error",  32'(rsp_error), 32'd3);
    chk("bad_result", rsp_result, 32'd0);
    chk("bad_acc",    acc, acc_before);
    chk("bad_alu_op", 32'(alu_op), 32'(op_before));
    chk("bad_alu_a",  32'(alu_a), 32'd1);
`else
    issue(4'd7, 16'd5, 16'd6, 1'b0, SETTLE + 1, "bad");
    chk("bad_error",  32'(rsp_error), 32'd0);
    chk("bad_result", rsp_result, 32'd0);
    chk("bad_acc",    acc, 32'd0);
    chk("bad_alu_op", 32'(alu_op), 32'd7);
    chk("bad_alu_a",  32'(alu_a), 32'd5);
`endif
    consume("bad");

    // Give the accumulator a nonzero value, then reset during ISSUE.
    issue(4'd0, 16'd40, 16'd2, 1'b0, SETTLE + 1, "pre");
    chk("pre_acc", acc, 32'd42);
    consume("pre");
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 4'd0;
    cmd_a     = 16'd7;
    cmd_b     = 16'd8;
    cmd_chain = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("rstmid_in_issue", 32'(cmd_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstmid_acc",       acc, 32'd0);
    chk("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rstmid_alu_a",     32'(alu_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rstmid_no_rsp",    32'(rsp_valid), 32'd0);
    chk("rstmid_ready_end", 32'(cmd_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
